// File: rtl/output_buf.sv
// output_buf: byte-addressable LED / 7-segment / LCD output registers
// on the LSU peripheral path with combinational load readback.
module output_buf (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_st_en,
  output logic [31:0] o_output_buf_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  logic [31:0]     ledr_q;
  logic [31:0]     ledg_q;
  logic [31:0]     lcd_q;
  logic [7:0][6:0] hex_q;

  logic [2:0]      size;
  logic [7:0]      base;
  logic [3:0][7:0] lane_addr;
  logic [3:0]      lane_act;
  logic [3:0][7:0] lane_rd;

  // Only the low address byte is decoded by this block.
  logic unused_addr;
  assign unused_addr = ^i_lsu_addr[31:8];

  // Access size in bytes; zero marks an unsupported func3.
  always_comb begin
    size = 3'd0;
    unique case (i_func3)
      3'b000, 3'b100: size = 3'd1;
      3'b001, 3'b101: size = 3'd2;
      3'b010:         size = 3'd4;
      default:        size = 3'd0;
    endcase
  end

  // Effective base: drop the sub-size address bits.
  always_comb begin
    base = i_lsu_addr[7:0];
    if (size == 3'd4) begin
      base[1:0] = 2'b00;
    end else if (size == 3'd2) begin
      base[0] = 1'b0;
    end
  end

  // Per-byte lane address (mod 256) and lane-active flag.
  always_comb begin
    lane_addr = '0;
    lane_act  = '0;
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = base + 8'(k);
      lane_act[k]  = (3'(k) < size);
    end
  end

  // Register file: each active lane commits to its own byte.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      hex_q  <= {8{7'h7F}};
    end else if (i_st_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_act[k]) begin
          unique case (1'b1)
            lane_addr[k][7:2] == 6'h00:
              ledr_q[{lane_addr[k][1:0], 3'b000} +: 8]
                <= i_st_data[8*k +: 8];
            lane_addr[k][7:2] == 6'h04:
              ledg_q[{lane_addr[k][1:0], 3'b000} +: 8]
                <= i_st_data[8*k +: 8];
            lane_addr[k][7:3] == 5'h04:
              hex_q[lane_addr[k][2:0]]
                <= i_st_data[8*k +: 7];
            lane_addr[k][7:2] == 6'h0C:
              lcd_q[{lane_addr[k][1:0], 3'b000} +: 8]
                <= i_st_data[8*k +: 8];
            default: ;
          endcase
        end
      end
    end
  end

  // Per-lane byte fetch; reserved offsets read as zero.
  always_comb begin
    lane_rd = '0;
    for (int k = 0; k < 4; k++) begin
      unique case (1'b1)
        lane_addr[k][7:2] == 6'h00:
          lane_rd[k] = ledr_q[{lane_addr[k][1:0], 3'b000} +: 8];
        lane_addr[k][7:2] == 6'h04:
          lane_rd[k] = ledg_q[{lane_addr[k][1:0], 3'b000} +: 8];
        lane_addr[k][7:3] == 5'h04:
          lane_rd[k] = {1'b0, hex_q[lane_addr[k][2:0]]};
        lane_addr[k][7:2] == 6'h0C:
          lane_rd[k] = lcd_q[{lane_addr[k][1:0], 3'b000} +: 8];
        default:
          lane_rd[k] = 8'h00;
      endcase
    end
  end

  // Assemble readback; bytes beyond the access size stay zero.
  always_comb begin
    o_output_buf_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (lane_act[k]) begin
        o_output_buf_data[8*k +: 8] = lane_rd[k];
      end
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];

endmodule

// File: tb/tb_output_buf.sv
// tb_output_buf: directed stores/loads against output_buf
// with hand-computed expected register and readback values.
module tb_output_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  func3 = 3'b010;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic        sen = 1'b0;
  logic [31:0] rdata;
  logic [31:0] ledr;
  logic [31:0] ledg;
  logic [31:0] lcd;
  logic [6:0]  hex [8];

  int checks = 0;
  int errors = 0;

  output_buf dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_func3           (func3),
    .i_lsu_addr        (addr),
    .i_st_data         (sdata),
    .i_st_en           (sen),
    .o_output_buf_data (rdata),
    .o_io_ledr         (ledr),
    .o_io_ledg         (ledg),
    .o_io_hex0         (hex[0]),
    .o_io_hex1         (hex[1]),
    .o_io_hex2         (hex[2]),
    .o_io_hex3         (hex[3]),
    .o_io_hex4         (hex[4]),
    .o_io_hex5         (hex[5]),
    .o_io_hex6         (hex[6]),
    .o_io_hex7         (hex[7]),
    .o_io_lcd          (lcd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_hex(input string tag,
                         input logic [55:0] exp);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s hex%0d", tag, n),
          {25'd0, hex[n]}, {25'd0, exp[7*n +: 7]});
    end
  endtask

  task automatic st(input logic [2:0] f,
                    input logic [7:0] a,
                    input logic [31:0] d);
    @(negedge clk);
    func3 = f;
    addr  = {24'hA5A5A5, a};
    sdata = d;
    sen   = 1'b1;
    @(posedge clk);
    #1;
    sen   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] f,
                    input logic [7:0] a);
    func3 = f;
    addr  = {24'h5A5A5A, a};
    sen   = 1'b0;
    #1;
  endtask

  initial begin
    // Reset with no clock edge yet.
    func3 = 3'b010;
    addr  = 32'h0000_0020;
    #2;
    rst = 1'b1;
    #1;
    chk("rst ledr", ledr, 32'h0);
    chk("rst ledg", ledg, 32'h0);
    chk("rst lcd", lcd, 32'h0);
    chk_hex("rst", {8{7'h7F}});
    chk("rst rd 0x20", rdata, 32'h7F7F7F7F);
    @(negedge clk);
    rst = 1'b0;

    // Word store; same-cycle load sees old value.
    @(negedge clk);
    func3 = 3'b010;
    addr  = 32'h0000_0000;
    sdata = 32'hDEADBEEF;
    sen   = 1'b1;
    #1;
    chk("same-cycle ld", rdata, 32'h0);
    @(posedge clk);
    #1;
    sen = 1'b0;
    chk("ledr word", ledr, 32'hDEADBEEF);
    rd(3'b010, 8'h00);
    chk("rd ledr", rdata, 32'hDEADBEEF);
    rd(3'b100, 8'h03);
    chk("rd lbu 0x03", rdata, 32'h000000DE);
    rd(3'b101, 8'h03);
    chk("rd lhu 0x03", rdata, 32'h0000DEAD);

    // Half then byte into LEDG.
    st(3'b001, 8'h13, 32'hCAFE1234);
    chk("ledg half", ledg, 32'h12340000);
    st(3'b000, 8'h11, 32'h123456AB);
    chk("ledg byte", ledg, 32'h1234AB00);
    rd(3'b000, 8'h11);
    chk("rd lb 0x11", rdata, 32'h000000AB);
    rd(3'b001, 8'h13);
    chk("rd lh 0x13", rdata, 32'h00001234);

    // Word into HEX4..7; bit 7 dropped.
    st(3'b010, 8'h24, 32'hFF8A0540);
    chk_hex("hexw", {7'h7F, 7'h0A, 7'h05, 7'h40,
                     {4{7'h7F}}});
    rd(3'b010, 8'h24);
    chk("rd hex 0x24", rdata, 32'h7F0A0540);

    // Reserved offsets and unsupported func3.
    st(3'b010, 8'h08, 32'hFFFFFFFF);
    st(3'b010, 8'h3C, 32'hFFFFFFFF);
    st(3'b011, 8'h30, 32'hFFFFFFFF);
    chk("rsv ledr", ledr, 32'hDEADBEEF);
    chk("rsv ledg", ledg, 32'h1234AB00);
    chk("rsv lcd", lcd, 32'h0);
    rd(3'b010, 8'h08);
    chk("rd 0x08", rdata, 32'h0);
    rd(3'b010, 8'h3C);
    chk("rd 0x3C", rdata, 32'h0);
    rd(3'b011, 8'h00);
    chk("rd f3=011", rdata, 32'h0);

    // st_en low holds everything.
    @(negedge clk);
    func3 = 3'b010;
    addr  = 32'h0000_0000;
    sdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    chk("hold ledr", ledr, 32'hDEADBEEF);

    // Misaligned word lands on 0x30.
    st(3'b010, 8'h32, 32'h11223344);
    chk("lcd word", lcd, 32'h11223344);

    // Reset mid-sequence.
    st(3'b000, 8'h30, 32'h00000055);
    chk("lcd byte", lcd, 32'h11223355);
    @(negedge clk);
    func3 = 3'b000;
    addr  = 32'h0000_0030;
    sdata = 32'h00000066;
    sen   = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("async rst lcd", lcd, 32'h0);
    chk("async rst ledr", ledr, 32'h0);
    @(posedge clk);
    #1;
    chk("rst store lost", lcd, 32'h0);
    chk_hex("rst2", {8{7'h7F}});
    @(negedge clk);
    rst = 1'b0;
    sen = 1'b0;
    st(3'b000, 8'h30, 32'h00000077);
    chk("post-rst lcd", lcd, 32'h00000077);
    rd(3'b010, 8'h30);
    chk("rd lcd", rdata, 32'h00000077);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/output_buf.md
# output_buf

Memory-mapped output peripheral on the LSU data path, serving stores and load readback for the board output devices. Red LEDs, green LEDs, eight 7-segment digits and the LCD word are held in byte-addressable registers. The block sits beside the input buffer in the LSU peripheral region. The LSU decodes the region and hands this block the low address byte, the store data and the access size.

## Interface

Parameters:
- none; the address map below is fixed.

Ports:
- i_clk  in  1  system clock; all register updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_func3  in  3  access size: 000 byte, 001 half, 010 word; 100/101 treated as 000/001 for readback
- i_lsu_addr  in  32  byte address; only [7:0] decoded
- i_st_data  in  32  store data, little-endian, byte 0 = [7:0]
- i_st_en  in  1  store strobe, asserted by LSU only when the address is in this region
- o_output_buf_data  out  32  combinational readback of the registers
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_io_hex0 … o_io_hex7  out  7 each  7-segment digits, active-low segments
- o_io_lcd  out  32  LCD control/data register

## Operation

- Byte map, offset = i_lsu_addr[7:0]:
  - LEDR at 0x00–0x03
  - LEDG at 0x10–0x13
  - HEXn at 0x20+n, n = 0..7, one byte each
  - LCD at 0x30–0x33
- All other offsets 0x00–0xFF are reserved: writes dropped, reads return 0.
- Alignment: the effective base is the offset with low bits forced.
  - Word: [1:0] forced to 00.
  - Half: [0] forced to 0.
  - Byte: unaltered.
- Store with i_st_en=1: byte k of i_st_data (k < size) is written to base+k.
  - Each byte is committed independently; a byte landing on a reserved offset is dropped, and the others still commit.
  - Base+k wraps modulo 256.
- HEX bytes store bits [6:0]; bit 7 is discarded and reads back as 0.
- Unsupported func3 (011, 110, 111): no write occurs, readback is 0.
- Readback: byte k = reg[base+k] for k < size; upper bytes are zero-filled. Sign extension is the LSU's job.
- Reset values:
  - LEDR 0, LEDG 0, LCD 0
  - HEX0–HEX7 = 7'h7F (all segments off)
  - o_output_buf_data follows the reset register contents.

## Timing

- A store is sampled on the rising edge with i_st_en=1. The register and the o_io_* outputs update at that edge.
- Readback is combinational from the registers.
  - A load in the same cycle as a store to the same byte returns the pre-store value.
  - The new value is visible from the next cycle.
- Back-to-back stores on consecutive cycles are all applied; the last writer to a byte wins. There is no stall and no busy state.
- i_reset asserted at any time forces all registers to reset values immediately, independent of i_clk. A store coinciding with reset is lost.
- After reset deassertion, the first rising edge with i_st_en=1 writes normally.
- i_st_en=0: registers hold, regardless of address, data or func3.

## Test plan

- Reset check: assert i_reset with no clock edge -> ledr=0, ledg=0, lcd=0, every hex=7'h7F; word read at 0x20 -> 0x7F7F7F7F.
- Word store 0xDEADBEEF to 0x00 -> next cycle ledr=0xDEADBEEF. A same-cycle word load at 0x00 returns the old value 0x00000000.
- Half store 0x1234 to 0x13 (aligned to 0x12) -> ledg=0x12340000; then byte store 0xAB to 0x11 -> ledg=0x1234AB00; byte load at 0x11 -> 0x000000AB.
- Word store 0xFF8A0540 to 0x24 -> hex4=7'h40, hex5=7'h05, hex6=7'h0A, hex7=7'h7F; word read at 0x24 -> 0x7F0A0540.
- Word store 0xFFFFFFFF to 0x08 (reserved) and to 0x3C -> no register changes, reads return 0. Store with func3=011 to 0x30 -> lcd unchanged.
- Reset mid-sequence: store 0x55 to 0x30, then assert i_reset on the next store's cycle -> lcd=0 immediately. The post-reset store of 0x77 to 0x30 -> lcd=0x00000077.
